seq_gen_tx: RTL
===============

SEQ_GEN_TX -- requirements
Module: seq_gen_tx

Interface
REQ-001 Parameter WIDTH, default 8, is the maximum pattern length in bits (supported range 2..16).
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst  input  1  Reset: synchronous, active-high.
REQ-004 start  input  1  Request to transmit. Sampled only in IDLE.
REQ-005 abort  input  1  Synchronous abort of the current transmission.
REQ-006 pattern  input  WIDTH  Pattern bits. Captured on an accepted start.
REQ-007 len  input  $clog2(WIDTH+1)  Number of pattern bits per frame. Captured on an accepted start.
REQ-008 reps  input  4  Extra repetitions. Total frames = reps+1. Captured on an accepted start.
REQ-009 dout  output  1  Serial data bit. Registered.
REQ-010 dvalid  output  1  dout carries a pattern bit this cycle. Registered.
REQ-011 busy  output  1  High in every state except IDLE.
REQ-012 done  output  1  Single-cycle completion pulse.
REQ-013 frame_cnt  output  4  Frames fully sent in the current transmission.

Function
REQ-014 The FSM SHALL have the states IDLE, SHIFT, GAP and FIN.
REQ-015 In IDLE, start=1 SHALL capture pattern, len and reps, clear frame_cnt, and move to SHIFT.
REQ-016 A captured len greater than WIDTH SHALL be clamped to WIDTH.
REQ-017 A captured len of 0 SHALL go directly to FIN: no dvalid, done one cycle after start.
REQ-018 Bits SHALL be sent MSB-first, from pattern[len-1] down to pattern[0], one bit per clock.
REQ-019 Timing: with start accepted at edge N, the first bit SHALL appear (dvalid=1) in the cycle after edge N.
REQ-020 A bit index counter SHALL reload to len-1 at the start of each frame and decrement per bit.
REQ-021 After bit 0: if frame_cnt+1 <= captured reps, frame_cnt SHALL increment and the next frame SHALL begin (via GAP when enabled); otherwise the FSM SHALL go to FIN.
REQ-022 FIN SHALL assert done for exactly one cycle, increment frame_cnt to reps+1, and return to IDLE on the next edge.
REQ-023 Whenever dvalid=0, dout SHALL be 0.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 The pattern, len and reps inputs SHALL be don't-care after capture.
REQ-026 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with dvalid=0 and no done pulse; frame_cnt SHALL hold its value.
REQ-027 abort and start together in IDLE: abort SHALL win and start SHALL be ignored.
REQ-028 reps=15 SHALL give 16 frames. frame_cnt SHALL reach 16 mod 16 = 0 in FIN, and done SHALL still pulse.
REQ-029 No output SHALL change combinationally from any input.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and clear dout, dvalid, done, frame_cnt and the internal shift register and counters; busy SHALL be 0.
REQ-031 rst SHALL override start and abort.
REQ-032 rst mid-frame SHALL truncate the frame with no done pulse.
REQ-033 Outputs SHALL be defined from the first edge with rst=1.

Configuration
REQ-034 Macro SEQ_GEN_TX_GAP_EN:
 - Defined: exactly one GAP cycle (dvalid=0, dout=0, busy=1) SHALL be inserted between consecutive frames.
 - Undefined: the GAP state SHALL be absent and frames SHALL be sent back-to-back with no idle cycle.
 - In both cases: no gap after the last frame, and no other behaviour changes.

Verification
REQ-035 WIDTH=8, pattern=8'h07, len=3, reps=0, start at edge N -> dout=1,1,1 with dvalid=1 in cycles N+1..N+3; done=1 in cycle N+4; frame_cnt=1.
REQ-036 pattern=8'hA5, len=8, reps=1, SEQ_GEN_TX_GAP_EN defined -> 10100101, one dvalid=0 cycle, 10100101; done after the 17th cycle.
REQ-037 Same stimulus as REQ-036 with SEQ_GEN_TX_GAP_EN undefined -> 16 contiguous dvalid cycles; done in cycle N+17.
REQ-038 len=0 -> no dvalid; done in cycle N+1. len=12 with WIDTH=8 -> 8 bits sent, starting from pattern[7].
REQ-039 abort asserted during the 2nd bit of pattern=8'hFF, len=8 -> dvalid=0 from the next cycle, no done, busy=0; a later start is accepted normally.
REQ-040 rst asserted mid-frame, and a second start pulsed while busy -> outputs return to their reset values at the rst edge; the ignored start produces no extra frames.

Source files
------------

// File: rtl/seq_gen_tx.sv
// ---------------------------------------------------------------------------
// seq_gen_tx -- serial pattern sequence transmitter
//
// Captures a pattern, a length and a repeat count on an accepted start.
// It then shifts the low 'len' bits of the pattern out MSB-first, one bit
// per clock, for reps+1 frames, and ends with a one-cycle done pulse.
//
// Optional feature (compile-time macro):
//   SEQ_GEN_TX_GAP_EN  defined   -> one idle GAP cycle between frames
//                      undefined -> frames are sent back-to-back
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   transmit request, sampled only in IDLE
//   abort      in   synchronous abort of the current transmission
//   pattern    in   [WIDTH]            pattern bits, captured on start
//   len        in   [$clog2(WIDTH+1)]  bits per frame, clamped to WIDTH
//   reps       in   [4]                extra repetitions (frames = reps+1)
//   dout       out  serial data bit (0 whenever dvalid=0)
//   dvalid     out  dout carries a pattern bit
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   frame_cnt  out  [4] frames fully sent in the current transmission
// ---------------------------------------------------------------------------
module seq_gen_tx #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    input  logic [3:0]                 reps,
    output logic                       dout,
    output logic                       dvalid,
    output logic                       busy,
    output logic                       done,
    output logic [3:0]                 frame_cnt
);

    localparam int LW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef SEQ_GEN_TX_GAP_EN
        GAP   = 2'd2,
`endif
        FIN   = 2'd3
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] pat_q;   // captured pattern, frame MSB aligned to bit WIDTH-1
    logic [WIDTH-1:0] sh;      // working shift register for the current frame
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    idx;     // index of the bit currently on dout
    logic [3:0]       reps_q;

    logic [LW-1:0]    len_c;
    logic [WIDTH-1:0] pat_al;
    logic             more_frames;

    // Clamp the requested length and left-align the pattern so the first
    // bit of every frame always sits at the MSB of the shift register.
    always_comb begin
        len_c  = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
        pat_al = pattern << (LW'(WIDTH) - len_c);
    end

    // Evaluated at bit 0 of a frame: another frame follows if the count of
    // completed frames (including this one) has not yet passed reps.
    assign more_frames = ({1'b0, frame_cnt} + 5'd1) <= {1'b0, reps_q};

    // busy decodes registered state only, so it never follows an input
    // combinationally.
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            sh        <= '0;
            len_q     <= '0;
            idx       <= '0;
            reps_q    <= '0;
            dout      <= 1'b0;
            dvalid    <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // NOTE: done defaults low every cycle and is only raised on the
            // edge entering FIN; with non-blocking assignments the later
            // assignment in this block wins, giving a clean one-cycle pulse.
            done <= 1'b0;

            if (abort && state != IDLE) begin
                // frame_cnt deliberately holds its value on abort.
                state  <= IDLE;
                dvalid <= 1'b0;
                dout   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            pat_q  <= pat_al;
                            len_q  <= len_c;
                            reps_q <= reps;
                            if (len_c == '0) begin
                                state     <= FIN;
                                done      <= 1'b1;
                                frame_cnt <= reps + 4'd1;
                            end else begin
                                // First bit is presented in the cycle right
                                // after the accepting edge.
                                state     <= SHIFT;
                                frame_cnt <= '0;
                                dout      <= pat_al[WIDTH-1];
                                dvalid    <= 1'b1;
                                sh        <= pat_al << 1;
                                idx       <= len_c - 1'b1;
                            end
                        end
                    end

                    SHIFT: begin
                        if (idx != '0) begin
                            dout <= sh[WIDTH-1];
                            sh   <= sh << 1;
                            idx  <= idx - 1'b1;
                        end else if (more_frames) begin
                            frame_cnt <= frame_cnt + 4'd1;
`ifdef SEQ_GEN_TX_GAP_EN
                            state  <= GAP;
                            dvalid <= 1'b0;
                            dout   <= 1'b0;
`else
                            // Back-to-back: reload straight from the capture.
                            dout <= pat_q[WIDTH-1];
                            sh   <= pat_q << 1;
                            idx  <= len_q - 1'b1;
`endif
                        end else begin
                            state     <= FIN;
                            done      <= 1'b1;
                            frame_cnt <= reps_q + 4'd1;  // wraps to 0 for reps=15
                            dvalid    <= 1'b0;
                            dout      <= 1'b0;
                        end
                    end

`ifdef SEQ_GEN_TX_GAP_EN
                    GAP: begin
                        state  <= SHIFT;
                        dout   <= pat_q[WIDTH-1];
                        dvalid <= 1'b1;
                        sh     <= pat_q << 1;
                        idx    <= len_q - 1'b1;
                    end
`endif

                    FIN: begin
                        state <= IDLE;
                    end

                    default: begin
                        state  <= IDLE;
                        dvalid <= 1'b0;
                        dout   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
